xm_control_unit: RTL
====================

Name: xm_control_unit

Overview:
- Multi-cycle sequencer for the X-Makina datapath.
- Drives every control strobe and select of the datapath (register file, ALU, address mux, MAR/OMDR, IR, status register) from the latched instruction word.
- Runs the external memory request/acknowledge handshake.
- Sits between the top-level memory interface and the datapath: one instruction at a time, no pipelining.

Parameters:
WORD, 16, datapath word width; ir_i and status_i are WORD bits.

Ports:
clk_i  in  1  system clock, rising edge
arst_i  in  1  asynchronous reset, active-low (0 = reset)
ir_i  in  WORD  instruction register contents from datapath
status_i  in  WORD  status register; [0]=C, [1]=Z, [2]=N, [3]=V
badMem_i  in  1  address decoder fault for current address
memAck_i  in  1  memory completes current request this cycle
memReq_o  out  1  memory request valid
memWe_o  out  1  request is a write
pcWr_o, regWr_o, memEn_o, irWr_o, statWr_o, flagsWr_o  out  1 each  datapath write strobes
byteOp_o, pcSel_o  out  1 each  byte operation; 0 = PC+2, 1 = PC+branch offset
aluBSel_o, adrSel_o, statWrMode_o, regWrMode_o  out  2 each  datapath selects
regWrSel_o, regWrAdr_o, regAdrA_o, regAdrB_o  out  3 each  register file write source and addresses
aluOp_o, flagsEn_o  out  4 each  ALU operation; flag update enables {V,N,Z,C}
fault_o  out  1  sticky memory fault, core halted

Behaviour:
- Instruction classes by ir_i[15:13]:
  - 000 BL: offset, link to R5.
  - 001 BRcc: cond in [12:10].
  - 010 ALU: aluOp [11:8], R/C [7], W/B [6], src [5:3], dst [2:0].
  - 011 MOVimm: dst [2:0].
  - 100 LD, 101 ST: byte [6], addr reg [5:3], data reg [2:0].
  - 110 LDR, 111 STR: same fields plus offset; adrSel = OFFSET.
- States: RST, FETCH, DECODE, EXEC, MEM, FAULT.
- Reset: while arst_i=0, state=RST, every output 0 and fault_o=0. Reset mid-operation aborts immediately with no completion strobes. RST moves to FETCH on the first clock after release.
- FETCH:
  - memReq_o=1, memEn_o=1, adrSel=PC, memWe_o=0.
  - Hold until memAck_i=1. In that cycle assert irWr_o=1 and pcWr_o=1 with pcSel_o=0, then go to DECODE.
- DECODE: one cycle, no strobes, register addresses presented. Go to MEM for classes 100-111, else EXEC.
- EXEC (one cycle, then FETCH):
  - ALU: regWr_o=1, regWrSel=ALU, aluBSel = const if R/C=1, else regB. flagsWr_o=1 with flagsEn_o=4'b1111, except MOV (aluOp 4'hC): flagsEn_o=0.
  - BRcc: pcWr_o=1, pcSel_o=1 only if the condition holds. Codes: 0 EQ (Z), 1 NE, 2 CS (C), 3 CC, 4 MI (N), 5 PL, 6 VS (V), 7 AL. Not taken = no strobes.
  - BL: regWr_o=1 to R5 with regWrSel=PC, and pcWr_o=1 with pcSel_o=1, in the same cycle.
  - MOVimm: regWr_o=1, regWrSel=IMM.
- MEM:
  - memReq_o=1, memEn_o=1, memWe_o=1 for ST/STR. byteOp_o=ir_i[6]; adrSel as per class.
  - Hold all request outputs stable until memAck_i.
  - On ack: loads assert regWr_o=1 with regWrSel=MEM, then go to FETCH.
- Faults and halt:
  - badMem_i=1 during any cycle with memReq_o=1 suppresses irWr/regWr/pcWr that cycle and goes to FAULT. Takes priority over a simultaneous memAck_i.
  - FAULT: fault_o=1, all other outputs 0. Exit only by reset.
- Latencies with zero-wait memory:
  - ALU, branch, MOV: 3 cycles.
  - Loads and stores: 3 cycles.
  - Each memory wait cycle adds 1.
- memAck_i while memReq_o=0 is ignored.

Test Plan:
- Release reset with memAck_i tied 1, ir_i=16'h4100 (ADD R0,R0) -> FETCH/DECODE/EXEC repeat every 3 cycles; irWr_o and pcWr_o pulse on cycle 1 of each; regWr_o and flagsWr_o pulse on cycle 3 with flagsEn_o=4'hF.
- Fetch with memAck_i delayed 4 cycles -> memReq_o, memEn_o and adrSel held 5 cycles; irWr_o pulses once, on the ack cycle only.
- BRcc EQ with status_i[1]=1, then with status_i[1]=0 -> first: pcWr_o=1, pcSel_o=1 in EXEC; second: no strobes in EXEC.
- ST, ir_i=16'hA013, ack after 2 cycles -> memWe_o=1 for 3 cycles; regWr_o stays 0; return to FETCH.
- LD with badMem_i=1 and memAck_i=1 in the same cycle -> no regWr_o; fault_o=1 from the next cycle; stays halted until arst_i pulses 0.
- arst_i=0 asserted mid-MEM wait -> all outputs 0 asynchronously; after release, the first FETCH request appears on the second clock.

Source files
------------

// File: rtl/xm_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : xm_control_unit
// Purpose  : Multi-cycle sequencer for the X-Makina datapath. Decodes the
//            latched instruction word, drives every datapath strobe/select
//            and runs the external memory request/acknowledge handshake.
//            One instruction at a time: FETCH -> DECODE -> EXEC | MEM.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1     system clock, rising edge
//   arst_i         in   1     asynchronous reset, active-low
//   ir_i           in   WORD  instruction register contents
//   status_i       in   WORD  status register, [0]=C [1]=Z [2]=N [3]=V
//   badMem_i       in   1     address decoder fault for current address
//   memAck_i       in   1     memory completes current request this cycle
//   memReq_o       out  1     memory request valid
//   memWe_o        out  1     request is a write
//   pcWr_o .. flagsWr_o  out  1  datapath write strobes
//   byteOp_o       out  1     byte-wide operation
//   pcSel_o        out  1     0 = PC+2, 1 = PC+branch offset
//   aluBSel_o      out  2     0 = register B, 1 = constant
//   adrSel_o       out  2     0 = idle, 1 = PC, 2 = address register,
//                             3 = address register + offset
//   statWrMode_o   out  2     status write mode (no status-writing class
//                             exists in this ISA subset, held at 0)
//   regWrMode_o    out  2     0 = word write, 1 = byte write
//   regWrSel_o     out  3     0 = none, 1 = ALU, 2 = PC (link), 3 = IMM,
//                             4 = MEM
//   regWrAdr_o     out  3     register file write address
//   regAdrA_o      out  3     register file read port A (dst / data reg)
//   regAdrB_o      out  3     register file read port B (src / addr reg)
//   aluOp_o        out  4     ALU operation
//   flagsEn_o      out  4     flag update enables {V,N,Z,C}
//   fault_o        out  1     sticky memory fault, core halted
// ============================================================================
module xm_control_unit #(
  parameter int WORD = 16
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic [WORD-1:0] ir_i,
  input  logic [WORD-1:0] status_i,
  input  logic            badMem_i,
  input  logic            memAck_i,
  output logic            memReq_o,
  output logic            memWe_o,
  output logic            pcWr_o,
  output logic            regWr_o,
  output logic            memEn_o,
  output logic            irWr_o,
  output logic            statWr_o,
  output logic            flagsWr_o,
  output logic            byteOp_o,
  output logic            pcSel_o,
  output logic [1:0]      aluBSel_o,
  output logic [1:0]      adrSel_o,
  output logic [1:0]      statWrMode_o,
  output logic [1:0]      regWrMode_o,
  output logic [2:0]      regWrSel_o,
  output logic [2:0]      regWrAdr_o,
  output logic [2:0]      regAdrA_o,
  output logic [2:0]      regAdrB_o,
  output logic [3:0]      aluOp_o,
  output logic [3:0]      flagsEn_o,
  output logic            fault_o
);

  // State encoding
  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  // Instruction classes, ir_i[15:13]
  localparam logic [2:0] C_BL   = 3'b000;
  localparam logic [2:0] C_BR   = 3'b001;
  localparam logic [2:0] C_ALU  = 3'b010;
  localparam logic [2:0] C_MOVI = 3'b011;

  // Select encodings (0 is always the idle value)
  localparam logic [1:0] ADR_PC    = 2'd1;
  localparam logic [1:0] ADR_REG   = 2'd2;
  localparam logic [1:0] ADR_OFF   = 2'd3;
  localparam logic [1:0] ALUB_REG  = 2'd0;
  localparam logic [1:0] ALUB_CONST = 2'd1;
  localparam logic [2:0] WRS_ALU   = 3'd1;
  localparam logic [2:0] WRS_PC    = 3'd2;
  localparam logic [2:0] WRS_IMM   = 3'd3;
  localparam logic [2:0] WRS_MEM   = 3'd4;
  localparam logic [3:0] ALU_MOV   = 4'hC;
  localparam logic [2:0] LINK_REG  = 3'd5;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_cond;
  logic [2:0] w_class;
  logic       w_unused;

  assign w_class  = ir_i[15:13];
  // Only the four condition flags of the status word are consumed here.
  assign w_unused = ^status_i[WORD-1:4];

  // Branch condition evaluation
  always_comb begin
    w_cond = 1'b0;
    case (ir_i[12:10])
      3'd0: w_cond =  status_i[1];   // EQ
      3'd1: w_cond = ~status_i[1];   // NE
      3'd2: w_cond =  status_i[0];   // CS
      3'd3: w_cond = ~status_i[0];   // CC
      3'd4: w_cond =  status_i[2];   // MI
      3'd5: w_cond = ~status_i[2];   // PL
      3'd6: w_cond =  status_i[3];   // VS
      default: w_cond = 1'b1;        // AL
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are decoded from the state (and, on ack cycles, the handshake
  // inputs) so that reset forces every output to zero asynchronously.
  always_comb begin
    w_next       = r_state;
    memReq_o     = 1'b0;
    memWe_o      = 1'b0;
    pcWr_o       = 1'b0;
    regWr_o      = 1'b0;
    memEn_o      = 1'b0;
    irWr_o       = 1'b0;
    statWr_o     = 1'b0;
    flagsWr_o    = 1'b0;
    byteOp_o     = 1'b0;
    pcSel_o      = 1'b0;
    aluBSel_o    = 2'd0;
    adrSel_o     = 2'd0;
    statWrMode_o = 2'd0;
    regWrMode_o  = 2'd0;
    regWrSel_o   = 3'd0;
    regWrAdr_o   = 3'd0;
    regAdrA_o    = 3'd0;
    regAdrB_o    = 3'd0;
    aluOp_o      = 4'd0;
    flagsEn_o    = 4'd0;
    fault_o      = 1'b0;

    // Register addresses are valid once the instruction word is latched.
    if (r_state == S_DECODE || r_state == S_EXEC || r_state == S_MEM) begin
      regAdrA_o  = ir_i[2:0];
      regAdrB_o  = ir_i[5:3];
      regWrAdr_o = ir_i[2:0];
    end

    case (r_state)
      S_RST: begin
        w_next = S_FETCH;
      end

      S_FETCH: begin
        memReq_o = 1'b1;
        memEn_o  = 1'b1;
        adrSel_o = ADR_PC;
        // A decoder fault wins over a simultaneous acknowledge.
        if (badMem_i) begin
          w_next = S_FAULT;
        end else if (memAck_i) begin
          irWr_o = 1'b1;
          pcWr_o = 1'b1;
          w_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Classes 1xx are all memory accesses.
        w_next = ir_i[15] ? S_MEM : S_EXEC;
      end

      S_EXEC: begin
        w_next = S_FETCH;
        case (w_class)
          C_BL: begin
            regWr_o    = 1'b1;
            regWrSel_o = WRS_PC;
            regWrAdr_o = LINK_REG;
            pcWr_o     = 1'b1;
            pcSel_o    = 1'b1;
          end
          C_BR: begin
            pcWr_o  = w_cond;
            pcSel_o = w_cond;
          end
          C_ALU: begin
            aluOp_o     = ir_i[11:8];
            aluBSel_o   = ir_i[7] ? ALUB_CONST : ALUB_REG;
            byteOp_o    = ir_i[6];
            regWr_o     = 1'b1;
            regWrSel_o  = WRS_ALU;
            regWrMode_o = {1'b0, ir_i[6]};
            flagsWr_o   = 1'b1;
            // MOV leaves the flags untouched.
            flagsEn_o   = (ir_i[11:8] == ALU_MOV) ? 4'b0000 : 4'b1111;
          end
          C_MOVI: begin
            regWr_o    = 1'b1;
            regWrSel_o = WRS_IMM;
          end
          default: begin
          end
        endcase
      end

      S_MEM: begin
        memReq_o = 1'b1;
        memEn_o  = 1'b1;
        memWe_o  = ir_i[13];                   // ST / STR
        byteOp_o = ir_i[6];
        adrSel_o = ir_i[14] ? ADR_OFF : ADR_REG; // LDR / STR use offset
        if (badMem_i) begin
          w_next = S_FAULT;
        end else if (memAck_i) begin
          if (!ir_i[13]) begin
            regWr_o     = 1'b1;
            regWrSel_o  = WRS_MEM;
            regWrMode_o = {1'b0, ir_i[6]};
          end
          w_next = S_FETCH;
        end
      end

      S_FAULT: begin
        fault_o   = 1'b1;
        regAdrA_o = 3'd0;
        w_next    = S_FAULT;
      end

      default: begin
        w_next = S_RST;
      end
    endcase
  end

endmodule
`default_nettype wire
